pong_match_ctrl: RTL and testbench

- Parametrised match-control FSM for the pong design. Replaces the fixed two-player game-state logic in the top level.
- Owns per-player scores, the serve delay, the pause toggle, and a BCD countdown match timer.
- Supports N players and two end-of-match modes: time limit only, or time limit plus first-to-WIN_SCORE.
- Consumes miss/tick strobes from the ball engine and the 1 Hz divider. Drives play enable, serve pulse, scores, timer digits and winner mask for the display blocks.

---
 rtl/pong_match_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Match control for pong: per-player scores, serve delay, pause toggle,
// BCD countdown timer and end-of-match winner mask for N players.
module pong_match_ctrl #(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 3,
    parameter int WIN_SCORE = 7,
    parameter int SERVE_SEC = 2,
    parameter int MATCH_MIN = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         mode,
    input  logic                         sec_tick,
    input  logic [N_PLAYERS-1:0]         miss,
    output logic [2:0]                   state,
    output logic                         play_en,
    output logic                         serve,
    output logic [N_PLAYERS*SCORE_W-1:0] scores,
    output logic [3:0]                   t_min,
    output logic [3:0]                   t_sec1,
    output logic [3:0]                   t_sec2,
    output logic [N_PLAYERS-1:0]         winner
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int AW = SCORE_W + 2;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [AW-1:0]      acc_t;

    localparam score_t     SC_MAX = '1;
    localparam score_t     WIN_V  = score_t'(WIN_SCORE);
    localparam acc_t       ONE    = acc_t'(1);
    localparam logic [3:0] SRV_V  = 4'(SERVE_SEC);
    localparam logic [3:0] MIN_V  = 4'(MATCH_MIN);

    logic [2:0]          state_q, state_nx;
    logic [3:0]          cnt_q, cnt_nx;
    logic                mode_q, mode_nx;
    score_t              sc_q [N_PLAYERS];
    score_t              sc_nx [N_PLAYERS];
    logic [3:0]          min_q, min_nx;
    logic [3:0]          s1_q, s1_nx;
    logic [3:0]          s2_q, s2_nx;
    logic                play_en_nx;
    logic                serve_nx;
    logic [N_PLAYERS-1:0] win_nx;
    logic                t_zero;
    logic                hit_win;
    logic                any_win;
    score_t              mx;
    acc_t                inc;
    acc_t                sum;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            for (int j = 0; j < N_PLAYERS; j++) sc_q[j] <= '0;
            min_q   <= MIN_V;
            s1_q    <= '0;
            s2_q    <= '0;
            play_en <= 1'b0;
            serve   <= 1'b0;
            winner  <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            mode_q  <= mode_nx;
            sc_q    <= sc_nx;
            min_q   <= min_nx;
            s1_q    <= s1_nx;
            s2_q    <= s2_nx;
            play_en <= play_en_nx;
            serve   <= serve_nx;
            winner  <= win_nx;
        end
    end

    // Next state plus score, timer and serve-counter updates
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        mode_nx  = mode_q;
        sc_nx    = sc_q;
        min_nx   = min_q;
        s1_nx    = s1_q;
        s2_nx    = s2_q;
        t_zero   = 1'b0;
        hit_win  = 1'b0;
        inc      = '0;
        sum      = '0;
        unique case (state_q)
            S_IDLE: begin
                for (int j = 0; j < N_PLAYERS; j++) sc_nx[j] = '0;
                min_nx = MIN_V;
                s1_nx  = '0;
                s2_nx  = '0;
                if (start) begin
                    mode_nx  = mode;
                    cnt_nx   = SRV_V;
                    state_nx = S_SERVE;
                end
            end
            S_SERVE: begin
                if (cnt_q == 4'd0) begin
                    state_nx = S_PLAY;
                end else if (sec_tick) begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            S_PLAY: begin
                if (sec_tick) begin
                    unique case (1'b1)
                        (s2_q != 4'd0): begin
                            s2_nx = s2_q - 4'd1;
                        end
                        (s2_q == 4'd0 && s1_q != 4'd0): begin
                            s1_nx = s1_q - 4'd1;
                            s2_nx = 4'd9;
                        end
                        (s2_q == 4'd0 && s1_q == 4'd0 && min_q != 4'd0): begin
                            min_nx = min_q - 4'd1;
                            s1_nx  = 4'd5;
                            s2_nx  = 4'd9;
                        end
                        default: ;
                    endcase
                end
                for (int j = 0; j < N_PLAYERS; j++) begin
                    inc = '0;
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (i != j && miss[i]) inc = inc + ONE;
                    end
                    sum = acc_t'(sc_q[j]) + inc;
                    if (sum > acc_t'(SC_MAX)) sc_nx[j] = SC_MAX;
                    else sc_nx[j] = sum[SCORE_W-1:0];
                    if (sc_nx[j] >= WIN_V) hit_win = 1'b1;
                end
                t_zero = (min_nx == 4'd0) && (s1_nx == 4'd0) && (s2_nx == 4'd0);
                if (t_zero || (mode_q && hit_win)) begin
                    state_nx = S_OVER;
                end else if (|miss) begin
                    state_nx = S_SERVE;
                    cnt_nx   = SRV_V;
                end else if (pause) begin
                    state_nx = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause) state_nx = S_PLAY;
            end
            S_OVER: begin
                if (start) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Play enable, serve pulse and winner mask for the coming cycle
    always_comb begin
        play_en_nx = (state_nx == S_PLAY);
        serve_nx   = (state_q == S_SERVE) && (state_nx == S_PLAY);
        win_nx     = '0;
        mx         = '0;
        any_win    = 1'b0;
        if (state_nx == S_OVER) begin
            for (int j = 0; j < N_PLAYERS; j++) begin
                if (sc_nx[j] >= WIN_V) any_win = 1'b1;
                if (sc_nx[j] > mx) mx = sc_nx[j];
            end
            for (int j = 0; j < N_PLAYERS; j++) begin
                if (mode_q && any_win) win_nx[j] = (sc_nx[j] >= WIN_V);
                else win_nx[j] = (sc_nx[j] == mx);
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_sc
        assign scores[g*SCORE_W +: SCORE_W] = sc_q[g];
    end

    assign state  = state_q;
    assign t_min  = min_q;
    assign t_sec1 = s1_q;
    assign t_sec2 = s2_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: directed match scenarios with
// hand-computed expectations checked by a decoupled negedge monitor.
module tb_pong_match_ctrl;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int WN = 7;
    localparam int SS = 2;
    localparam int MM = 1;
    localparam int EW = 3 + 1 + 1 + N*SW + 12 + N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          mode = 1'b0;
    logic          sec_tick = 1'b0;
    logic [N-1:0]  miss = '0;
    logic [2:0]    state;
    logic          play_en;
    logic          serve;
    logic [N*SW-1:0] scores;
    logic [3:0]    t_min;
    logic [3:0]    t_sec1;
    logic [3:0]    t_sec2;
    logic [N-1:0]  winner;

    pong_match_ctrl #(
        .N_PLAYERS(N),
        .SCORE_W  (SW),
        .WIN_SCORE(WN),
        .SERVE_SEC(SS),
        .MATCH_MIN(MM)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .mode    (mode),
        .sec_tick(sec_tick),
        .miss    (miss),
        .state   (state),
        .play_en (play_en),
        .serve   (serve),
        .scores  (scores),
        .t_min   (t_min),
        .t_sec1  (t_sec1),
        .t_sec2  (t_sec2),
        .winner  (winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    string           qn[$];
    logic [EW-1:0]   qv[$];

    logic [2:0]      e_st;
    logic            e_sv;
    int              e_sc[N];
    logic [3:0]      e_min;
    logic [3:0]      e_s1;
    logic [3:0]      e_s2;
    logic [N-1:0]    e_w;

    function automatic logic [EW-1:0] pack(
        input logic [2:0]    st,
        input logic          pe,
        input logic          sv,
        input logic [N*SW-1:0] sc,
        input logic [11:0]   tm,
        input logic [N-1:0]  w
    );
        return {st, pe, sv, sc, tm, w};
    endfunction

    function automatic string fmt(input logic [EW-1:0] v);
        return $sformatf("st=%0d pe=%b sv=%b sc=%h t=%h w=%b",
                         v[EW-1 -: 3], v[EW-4], v[EW-5],
                         v[N+12 +: N*SW], v[N +: 12], v[N-1:0]);
    endfunction

    task automatic set_sc(input int a, input int b, input int c, input int d);
        e_sc[0] = a;
        e_sc[1] = b;
        e_sc[2] = c;
        e_sc[3] = d;
    endtask

    task automatic chk(input string nm);
        logic [N*SW-1:0] sc;
        for (int j = 0; j < N; j++) sc[j*SW +: SW] = SW'(e_sc[j]);
        qn.push_back(nm);
        qv.push_back(pack(e_st, e_st == 3'd2, e_sv, sc,
                          {e_min, e_s1, e_s2}, e_w));
    endtask

    task automatic cyc(input logic s, input logic p, input logic t,
                       input logic [N-1:0] ms);
        start    = s;
        pause    = p;
        sec_tick = t;
        miss     = ms;
        @(posedge clk);
        #1;
        start    = 1'b0;
        pause    = 1'b0;
        sec_tick = 1'b0;
        miss     = '0;
    endtask

    task automatic serve_seq(input string nm);
        cyc(1'b0, 1'b1, 1'b1, 4'b0000);
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd2;
        e_sv = 1'b1;
        chk(nm);
        e_sv = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, 4'b0000);
    endtask

    task automatic new_match();
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd0;
        e_w  = '0;
        chk("over_to_idle");
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        set_sc(0, 0, 0, 0);
        e_min = 4'(MM);
        e_s1  = 4'd0;
        e_s2  = 4'd0;
        chk("idle_clear");
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation
    always @(negedge clk) begin : mon
        string         nm;
        logic [EW-1:0] ev;
        logic [EW-1:0] av;
        if (qv.size() > 0) begin
            nm = qn.pop_front();
            ev = qv.pop_front();
            av = pack(state, play_en, serve, scores,
                      {t_min, t_sec1, t_sec2}, winner);
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL %s: got %s, expected %s", nm, fmt(av), fmt(ev));
            end
        end
    end

    initial begin
        e_st  = 3'd0;
        e_sv  = 1'b0;
        set_sc(0, 0, 0, 0);
        e_min = 4'(MM);
        e_s1  = 4'd0;
        e_s2  = 4'd0;
        e_w   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;

        mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd1;
        chk("start_serve");
        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        chk("serve_tick1");
        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        chk("serve_tick2");
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd2;
        e_sv = 1'b1;
        chk("serve_pulse");
        e_sv = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        chk("serve_one_cycle");

        cyc(1'b0, 1'b0, 1'b0, 4'b0011);
        set_sc(1, 1, 2, 2);
        e_st = 3'd1;
        chk("miss_0011");
        serve_seq("serve_after_miss");

        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        e_min = 4'd0;
        e_s1  = 4'd5;
        e_s2  = 4'd9;
        chk("tick_059");
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        e_st = 3'd3;
        chk("pause_enter");
        for (int i = 0; i < 10; i++)
            cyc(i == 3, 1'b0, 1'b1, (i == 5) ? 4'b0001 : 4'b0000);
        chk("pause_frozen");
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        e_st = 3'd2;
        chk("pause_exit");

        ticks(9);
        e_s1 = 4'd5;
        e_s2 = 4'd0;
        chk("t_050");
        ticks(41);
        e_s1 = 4'd0;
        e_s2 = 4'd9;
        chk("t_009");
        ticks(8);
        e_s2 = 4'd1;
        chk("t_001");
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        e_s2 = 4'd0;
        set_sc(1, 2, 3, 3);
        e_st = 3'd4;
        e_w  = 4'b1100;
        chk("timeout_with_miss");
        cyc(1'b0, 1'b1, 1'b1, 4'b1111);
        chk("over_frozen");
        new_match();
        cyc(1'b0, 1'b1, 1'b1, 4'b1111);
        chk("idle_ignore");

        mode = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd1;
        chk("start_mode1");
        mode = 1'b0;
        serve_seq("serve_m1");
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'b0010);
            set_sc(k, 0, k, k);
            e_st = 3'd1;
            chk("miss1_m1");
            serve_seq("serve_m1_loop");
        end
        cyc(1'b0, 1'b0, 1'b0, 4'b0100);
        set_sc(7, 1, 6, 7);
        e_st = 3'd4;
        e_w  = 4'b1001;
        chk("win_score");
        cyc(1'b0, 1'b0, 1'b1, 4'b0010);
        chk("win_frozen");
        new_match();

        mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd1;
        serve_seq("serve_m0");
        cyc(1'b0, 1'b0, 1'b0, 4'b1110);
        set_sc(3, 2, 2, 2);
        e_st = 3'd1;
        chk("miss_1110_a");
        serve_seq("serve_m0_a");
        cyc(1'b0, 1'b0, 1'b0, 4'b1110);
        set_sc(6, 4, 4, 4);
        e_st = 3'd1;
        chk("miss_1110_b");
        serve_seq("serve_m0_b");
        cyc(1'b0, 1'b0, 1'b0, 4'b1110);
        set_sc(7, 6, 6, 6);
        e_st = 3'd1;
        chk("saturate_mode0");
        serve_seq("serve_m0_c");
        ticks(59);
        e_min = 4'd0;
        e_s1  = 4'd0;
        e_s2  = 4'd1;
        chk("sat_t_001");
        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        e_s2 = 4'd0;
        e_st = 3'd4;
        e_w  = 4'b0001;
        chk("timeout_max");
        new_match();

        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd1;
        serve_seq("serve_r");
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        set_sc(0, 1, 1, 1);
        e_st = 3'd1;
        chk("miss_0001");
        serve_seq("serve_r2");
        cyc(1'b0, 1'b0, 1'b1, 4'b0000);
        e_min = 4'd0;
        e_s1  = 4'd5;
        e_s2  = 4'd9;
        chk("play_before_reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        e_st = 3'd0;
        set_sc(0, 0, 0, 0);
        e_min = 4'(MM);
        e_s1  = 4'd0;
        e_s2  = 4'd0;
        e_w   = '0;
        chk("reset_mid_play");
        @(negedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        e_st = 3'd1;
        chk("start_after_reset");

        repeat (3) @(negedge clk);
        if (qv.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", qv.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
